// File: rtl/proc_feeder.sv
// Program sequencer feeding instruction and immediate words to the bus processor.
// Follows the processor's time steps through Done, halts on a marker word and flags faults.
module proc_feeder #(
    parameter int ADDR_W = 5,
    parameter int WORD_W = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              LdEn,
    input  logic [ADDR_W-1:0] LdAddr,
    input  logic [WORD_W-1:0] LdData,
    input  logic              Start,
    input  logic              Stop,
    input  logic              Done,
    output logic [WORD_W-1:0] DIN,
    output logic              Run,
    output logic              ProcResetn,
    output logic              Busy,
    output logic              Finished,
    output logic              Error,
    output logic [ADDR_W-1:0] PC
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_IMM,
        S_WAIT,
        S_ERR
    } state_t;

    state_t state, state_nx;

    logic [WORD_W-1:0] mem [2**ADDR_W];
    logic [WORD_W-1:0] word;
    logic [2:0]        opcode;
    logic [ADDR_W-1:0] pc_p1, pc_p2, pc_nx;
    logic [1:0]        wait_cnt, wait_cnt_nx;
    logic              err_nx, fin_nx, active, active_nx;

    assign word   = mem[PC];
    assign opcode = word[8:6];
    assign pc_p1  = PC + ADDR_W'(1);
    assign pc_p2  = PC + ADDR_W'(2);

    always_ff @(posedge Clock) begin
        if (!Reset && state == S_IDLE && LdEn)
            mem[LdAddr] <= LdData;
    end

    always_comb begin
        state_nx    = state;
        pc_nx       = PC;
        wait_cnt_nx = wait_cnt;
        err_nx      = Error;
        fin_nx      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (Start && !LdEn) begin
                    pc_nx    = '0;
                    err_nx   = 1'b0;
                    state_nx = S_FETCH;
                end
            end
            S_FETCH: begin
                if (word[15]) begin
                    state_nx = S_IDLE;
                    fin_nx   = 1'b1;
                end else if (opcode[2]) begin
                    state_nx = S_ERR;
                    err_nx   = 1'b1;
                end else if (opcode == 3'b001) begin
                    state_nx = S_IMM;
                end else begin
                    state_nx    = S_WAIT;
                    wait_cnt_nx = 2'd0;
                end
            end
            S_IMM: begin
                if (Done) begin
                    pc_nx    = pc_p2;
                    state_nx = S_FETCH;
                end else begin
                    state_nx = S_ERR;
                    err_nx   = 1'b1;
                end
            end
            S_WAIT: begin
                if (Done) begin
                    pc_nx    = pc_p1;
                    state_nx = S_FETCH;
                end else if (wait_cnt == 2'd2) begin
                    state_nx = S_ERR;
                    err_nx   = 1'b1;
                end else begin
                    wait_cnt_nx = wait_cnt + 2'd1;
                end
            end
            S_ERR: begin
                if (Start) begin
                    pc_nx    = '0;
                    err_nx   = 1'b0;
                    state_nx = S_FETCH;
                end
            end
            default: state_nx = S_IDLE;
        endcase
        // Abort overrides any progress or fault made this cycle
        if (Stop) begin
            state_nx = S_IDLE;
            pc_nx    = PC;
            fin_nx   = 1'b0;
            err_nx   = Error;
        end
        active_nx = (state_nx == S_FETCH) || (state_nx == S_IMM) ||
                    (state_nx == S_WAIT);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= S_IDLE;
            PC       <= '0;
            wait_cnt <= 2'd0;
            Error    <= 1'b0;
            Finished <= 1'b0;
            active   <= 1'b0;
        end else begin
            state    <= state_nx;
            PC       <= pc_nx;
            wait_cnt <= wait_cnt_nx;
            Error    <= err_nx;
            Finished <= fin_nx;
            active   <= active_nx;
        end
    end

    assign Busy       = active;
    assign Run        = active;
    assign ProcResetn = active;

    always_comb begin
        DIN = '0;
        unique case (state)
            S_FETCH, S_WAIT: DIN = word;
            S_IMM:           DIN = mem[pc_p1];
            default:         DIN = '0;
        endcase
    end

endmodule
